// File: rtl/mips32_core.sv
// Single-cycle MIPS32 integer core: fetch, decode, execute, memory access and
// writeback all complete in one clock. Instruction memory, register file and
// data memory live in sub-instances named imemory, registers and main_memory
// so their arrays can be preloaded and inspected by hierarchical name.

// Instruction memory: combinational read. The write port exists only so the
// array has a driver; the core ties it off and contents come from preload.
module mips32_imem #(
    parameter int WORDS = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] memory [0:WORDS-1];

    // optional program-load write port
    always_ff @(posedge clk) begin
        if (we) memory[waddr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

// 32x32 register file: two async read ports, one posedge write port.
// $0 is hardwired to zero on read and never written.
module mips32_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [0:31];

    // synchronous write, writes to $0 dropped
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) registers[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : registers[raddr2];
endmodule

// Word data memory: async read, posedge write.
module mips32_dmem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] memory [0:WORDS-1];

    // store on sw
    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

// Memory depths are assumed to be powers of two, so "index mod depth" is
// simply the low address bits above the byte offset.
module mips32_core #(
    parameter int IMEM_WORDS = 32,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc, pc_plus4, next_pc, instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, wdst;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, sext_imm, zext_imm, wdata, mem_addr, mem_rdata;
    logic        reg_we, mem_we;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign target   = instr[25:0];
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'h0, imm};
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs_val + sext_imm;

    mips32_imem #(.WORDS(IMEM_WORDS)) imemory (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata (32'h0),
        .addr  (pc[IAW+1:2]),
        .rdata (instr)
    );

    // no architectural writes happen while reset is asserted
    mips32_regfile registers (
        .clk    (clk),
        .we     (reg_we && !reset),
        .waddr  (wdst),
        .wdata  (wdata),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    mips32_dmem #(.WORDS(DMEM_WORDS)) main_memory (
        .clk   (clk),
        .we    (mem_we && !reset),
        .addr  (mem_addr[DAW+1:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    // program counter
    always_ff @(posedge clk) begin
        if (reset) pc <= 32'h0;
        else       pc <= next_pc;
    end

    // decode + execute: result, destination, write enables and next PC.
    // Anything not recognised falls through as a NOP with PC+4.
    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wdst    = rd;
        wdata   = 32'h0;
        next_pc = pc_plus4;
        case (opcode)
            6'h00: begin
                reg_we = 1'b1;
                case (funct)
                    6'h20, 6'h21: wdata = rs_val + rt_val;
                    6'h22, 6'h23: wdata = rs_val - rt_val;
                    6'h24: wdata = rs_val & rt_val;
                    6'h25: wdata = rs_val | rt_val;
                    6'h26: wdata = rs_val ^ rt_val;
                    6'h27: wdata = ~(rs_val | rt_val);
                    6'h2a: wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2b: wdata = {31'h0, rs_val < rt_val};
                    6'h00: wdata = rt_val << shamt;
                    6'h02: wdata = rt_val >> shamt;
                    6'h03: wdata = $unsigned($signed(rt_val) >>> shamt);
                    6'h04: wdata = rt_val << rs_val[4:0];
                    6'h06: wdata = rt_val >> rs_val[4:0];
                    6'h07: wdata = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                    6'h08: begin
                        reg_we  = 1'b0;
                        next_pc = rs_val;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin reg_we = 1'b1; wdst = rt; wdata = rs_val + sext_imm; end
            6'h0c: begin reg_we = 1'b1; wdst = rt; wdata = rs_val & zext_imm; end
            6'h0d: begin reg_we = 1'b1; wdst = rt; wdata = rs_val | zext_imm; end
            6'h0e: begin reg_we = 1'b1; wdst = rt; wdata = rs_val ^ zext_imm; end
            6'h0a: begin
                reg_we = 1'b1; wdst = rt;
                wdata  = {31'h0, $signed(rs_val) < $signed(sext_imm)};
            end
            6'h0b: begin reg_we = 1'b1; wdst = rt; wdata = {31'h0, rs_val < sext_imm}; end
            6'h0f: begin reg_we = 1'b1; wdst = rt; wdata = {imm, 16'h0}; end
            6'h23: begin reg_we = 1'b1; wdst = rt; wdata = mem_rdata; end
            6'h2b: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], target, 2'b00};
            6'h03: begin
                reg_we  = 1'b1;
                wdst    = 5'd31;
                wdata   = pc_plus4;
                next_pc = {pc_plus4[31:28], target, 2'b00};
            end
            default: ;
        endcase
    end

    // address bits beyond the memory depths are ignored by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[1:0], pc[31:IAW+2], mem_addr[1:0], mem_addr[31:DAW+2]};

    assign pc_o    = pc;
    assign instr_o = instr;
endmodule

// File: tb/tb_mips32_core.sv
// Bench for mips32_core: a directed program exercising the documented cases,
// then randomized programs, all checked against an instruction-level model.
module tb_mips32_core;
  logic        clk;
  logic        reset;
  logic [31:0] pc_o;
  logic [31:0] instr_o;

  int checks = 0;
  int errors = 0;

  // reference architectural state
  logic [31:0] m_imem [32];
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  mips32_core #(.IMEM_WORDS(32), .DMEM_WORDS(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .pc_o    (pc_o),
    .instr_o (instr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    r_ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    i_ins = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int tgt);
    j_ins = {6'(op), 26'(tgt)};
  endfunction

  // ISA-level model of one instruction
  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, npc, res, ea;
    logic [5:0]  op, fn;
    int          dst;
    bit          wr;
    ins = m_imem[(m_pc >> 2) % 32];
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = (ins[25:21] == 0) ? 32'h0 : m_reg[ins[25:21]];
    b   = (ins[20:16] == 0) ? 32'h0 : m_reg[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    npc = m_pc + 4;
    res = 0;
    wr  = 0;
    dst = ins[20:16];
    ea  = a + se;
    if (op == 0) begin
      dst = ins[15:11];
      wr  = 1;
      case (fn)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2a: res = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h2b: res = (a < b) ? 1 : 0;
        6'h00: res = b << ins[10:6];
        6'h02: res = b >> ins[10:6];
        6'h03: res = $signed(b) >>> ins[10:6];
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: res = $signed(b) >>> a[4:0];
        6'h08: begin wr = 0; npc = a; end
        default: wr = 0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin wr = 1; res = a + se; end
        6'h0c: begin wr = 1; res = a & ze; end
        6'h0d: begin wr = 1; res = a | ze; end
        6'h0e: begin wr = 1; res = a ^ ze; end
        6'h0a: begin wr = 1; res = ($signed(a) < $signed(se)) ? 1 : 0; end
        6'h0b: begin wr = 1; res = (a < se) ? 1 : 0; end
        6'h0f: begin wr = 1; res = {ins[15:0], 16'h0}; end
        6'h23: begin wr = 1; res = m_dmem[(ea >> 2) % 64]; end
        6'h2b: m_dmem[(ea >> 2) % 64] = b;
        6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
        6'h05: if (a != b) npc = m_pc + 4 + (se << 2);
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        6'h03: begin
          wr = 1; dst = 31; res = m_pc + 4;
          npc = {npc[31:28], ins[25:0], 2'b00};
        end
        default: ;
      endcase
    end
    if (wr && dst != 0) m_reg[dst] = res;
    m_pc = npc;
  endtask

  // driver: reset for two edges while loading model state into the DUT,
  // then run ncycles comparing PC/instruction every cycle and all state at the end
  task automatic run_program(input string name, input int ncycles);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) dut.imemory.memory[i] <= m_imem[i];
    for (int i = 0; i < 32; i++) dut.registers.registers[i] <= m_reg[i];
    for (int i = 0; i < 64; i++) dut.main_memory.memory[i] <= m_dmem[i];
    repeat (2) @(negedge clk);
    check({name, "_reset_pc"}, pc_o, 32'h0);
    reset = 1'b0;
    m_pc = 0;
    for (int c = 0; c < ncycles; c++) begin
      check($sformatf("%s_pc_c%0d", name, c), pc_o, m_pc);
      check($sformatf("%s_instr_c%0d", name, c), instr_o, m_imem[(m_pc >> 2) % 32]);
      model_step();
      @(negedge clk);
    end
    check({name, "_final_pc"}, pc_o, m_pc);
    for (int i = 1; i < 32; i++)
      check($sformatf("%s_reg%0d", name, i), dut.registers.registers[i], m_reg[i]);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_dmem%0d", name, i), dut.main_memory.memory[i], m_dmem[i]);
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) m_reg[i] = $urandom;
    m_reg[0] = 0;
    for (int i = 0; i < 64; i++) m_dmem[i] = $urandom;
  endtask

  function automatic logic [31:0] rand_instr();
    int ops [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a,
                     6'h0b, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h03, 6'h3f};
    int fns [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                     6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3f};
    int op;
    op = ops[$urandom_range(0, 15)];
    if (op == 0)
      return r_ins($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), fns[$urandom_range(0, 17)]);
    if (op == 6'h03) return j_ins(op, $urandom_range(0, 31));
    if (op == 6'h04 || op == 6'h05)
      return i_ins(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
    return i_ins(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
  endfunction

  initial begin
    reset = 1'b1;

    // directed program
    randomize_state();
    for (int i = 0; i < 32; i++) m_imem[i] = 32'h0;
    m_reg[1] = 32'd5;
    m_reg[2] = 32'hFFFF_FFFD;
    m_reg[8] = 32'h8000_0000;
    m_reg[13] = 32'h0;
    m_imem[0]  = r_ins(1, 2, 3, 0, 6'h20);      // add  $3,$1,$2
    m_imem[1]  = r_ins(1, 2, 11, 0, 6'h22);     // sub  $11,$1,$2
    m_imem[2]  = r_ins(2, 1, 4, 0, 6'h2a);      // slt  $4,$2,$1
    m_imem[3]  = r_ins(2, 1, 12, 0, 6'h2b);     // sltu $12,$2,$1
    m_imem[4]  = i_ins(6'h04, 1, 1, 2);         // 0x10: beq $1,$1,+2 -> 0x1C
    m_imem[5]  = i_ins(6'h08, 0, 13, 99);
    m_imem[6]  = i_ins(6'h08, 0, 13, 98);
    m_imem[7]  = r_ins(0, 8, 10, 4, 6'h03);     // sra  $10,$8,4
    m_imem[8]  = j_ins(6'h03, 11);              // 0x20: jal 0x2C
    m_imem[9]  = j_ins(6'h02, 9);               // 0x24: j 0x24
    m_imem[11] = i_ins(6'h0f, 0, 5, 16'h1234);  // lui  $5,0x1234
    m_imem[12] = i_ins(6'h0d, 5, 5, 16'h5678);  // ori  $5,$5,0x5678
    m_imem[13] = i_ins(6'h08, 0, 6, 16'hFFFF);  // addi $6,$0,-1
    m_imem[14] = i_ins(6'h08, 0, 0, 7);         // addi $0,$0,7
    m_imem[15] = i_ins(6'h2b, 0, 5, 8);         // sw   $5,8($0)
    m_imem[16] = i_ins(6'h23, 0, 7, 8);         // lw   $7,8($0)
    m_imem[17] = i_ins(6'h05, 1, 1, 5);         // bne  $1,$1 (not taken)
    m_imem[18] = r_ins(31, 0, 0, 0, 6'h08);     // jr   $31
    run_program("dir", 24);

    check("add", dut.registers.registers[3], 32'd2);
    check("sub", dut.registers.registers[11], 32'd8);
    check("slt", dut.registers.registers[4], 32'd1);
    check("sltu", dut.registers.registers[12], 32'd0);
    check("sra", dut.registers.registers[10], 32'hF800_0000);
    check("beq_skip", dut.registers.registers[13], 32'd0);
    check("lui_ori", dut.registers.registers[5], 32'h1234_5678);
    check("addi_neg", dut.registers.registers[6], 32'hFFFF_FFFF);
    check("r0_zero", dut.registers.registers[0], 32'd0);
    check("sw_mem", dut.main_memory.memory[2], 32'h1234_5678);
    check("lw", dut.registers.registers[7], 32'h1234_5678);
    check("jal_link", dut.registers.registers[31], 32'h24);
    check("j_self_loop", pc_o, 32'h24);

    // randomized programs
    for (int p = 0; p < 4; p++) begin
      randomize_state();
      for (int i = 0; i < 32; i++) m_imem[i] = rand_instr();
      run_program($sformatf("rnd%0d", p), 48);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
